mult_seq_n: RTL and testbench

- Parametrised sequential shift-add multiplier; successor to the combinational 32-bit MULT32/MULT32_U pair.
- One engine serves both signed and unsigned modes, selected per operation.
- Performs one multiplier bit per clock.
- Sits beside the ALU and serves multi-cycle MUL/MULU through a START/BUSY/DONE handshake, giving a 2*WIDTH-bit result split into HI/LO.

---
 rtl/mult_seq_n.sv | 133 +++++++++++++
 tb/tb_mult_seq_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed or unsigned per operation.
// Optional overflow flag output o_ovf is enabled by defining MULT_SEQ_OVF_FLAG_EN.
module mult_seq_n #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
`ifdef MULT_SEQ_OVF_FLAG_EN
  output logic             o_ovf,
`endif
  output logic [1:0]       o_dbg_state
);

  // Handshake: o_busy is high from the edge that accepts i_start until the edge
  // that loads o_hi/o_lo; o_done pulses for exactly that one following cycle.
  // i_start is only sampled in IDLE, so requests made while busy are dropped.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_accept;
  logic [WIDTH-1:0]       r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic [2*WIDTH-1:0]     r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_neg;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic [WIDTH:0]         w_addend;
  logic [WIDTH:0]         w_sum;
  logic [2*WIDTH-1:0]     w_result;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_accept = 1'b1;
        w_next   = S_CALC;
      end
      S_CALC: if (r_cnt == LAST_CNT) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Most-negative operands negate to themselves, which is the correct unsigned magnitude.
  assign w_a_mag  = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag  = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
  assign w_result = r_neg ? -r_acc : r_acc;

`ifdef MULT_SEQ_OVF_FLAG_EN
  logic r_sgn;
  logic w_ovf;
  assign w_ovf = r_sgn ? (w_result[2*WIDTH-1:WIDTH] != {WIDTH{w_result[WIDTH-1]}})
                       : (w_result[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sgn <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      if (w_accept)          r_sgn <= i_signed;
      if (r_state == S_FIX)  o_ovf <= w_ovf;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      o_hi     <= '0;
      o_lo     <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_mcand  <= w_a_mag;
          r_mplier <= w_b_mag;
          r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
          r_acc    <= '0;
          r_cnt    <= '0;
          o_busy   <= 1'b1;
        end
        S_CALC: begin
          // Carry-out of the upper-half add becomes the new MSB after the shift.
          r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          o_hi   <= w_result[2*WIDTH-1:WIDTH];
          o_lo   <= w_result[WIDTH-1:0];
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_seq_n.sv
// Testbench for mult_seq_n (WIDTH=32): table vectors, random ops against a 64-bit
// arithmetic model, and hand sequences for busy-ignore, reset abort and back-to-back.
module tb_mult_seq_n;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sgn = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;
`ifdef MULT_SEQ_OVF_FLAG_EN
  logic          ovf;
`endif

  mult_seq_n #(.WIDTH(W), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn),
    .i_a(a), .i_b(b), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done),
`ifdef MULT_SEQ_OVF_FLAG_EN
    .o_ovf(ovf),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic [2*W:0] exp_q[$];   // {ovf, hi, lo}

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: the true product of the operands, interpreted per signedness.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = longint'(x);
    uy = longint'(y);
    return ux * uy;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [63:0] p;
    longint sp;
    p = ref_prod(x, y, s);
    sp = longint'(p);
    if (s) return (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
    return p >= 64'h1_0000_0000;
  endfunction

  // Driver: called just after a rising edge; runs one op and scores it.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input logic e_ovf);
    int lat;
    logic [2*W:0] e;
    exp_q.push_back({e_ovf, e_hi, e_lo});
    a = x; b = y; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
    chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(W + 1));
    e = exp_q.pop_front();
    chk({tag, " product"}, {hi, lo}, e[2*W-1:0]);
`ifdef MULT_SEQ_OVF_FLAG_EN
    chk({tag, " ovf"}, 64'(ovf), 64'(e[2*W]));
`endif
    @(posedge clk); #1;
    chk({tag, " done_pulse_len"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic s;
    logic [63:0] p;
    int busy_cnt, done_cnt;
    int d0, d1;
    logic [63:0] res;

    vecs[0] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 1'b1};
    vecs[4] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000, 1'b0};
    vecs[5] = '{32'h00000007, 32'h00000006, 1'b0, 32'h00000000, 32'h0000002A, 1'b0};
    vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[7] = '{32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000, 1'b1};
    vecs[8] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // table vectors
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
             vecs[i].hi, vecs[i].lo, vecs[i].ovf);

    // random ops against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: x = 32'h80000000;
        1: x = 32'($urandom_range(0, 15));
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      s = 1'($urandom_range(0, 1));
      p = ref_prod(x, y, s);
      run_op($sformatf("rnd%0d", i), x, y, s, p[63:32], p[31:0], ref_ovf(x, y, s));
    end

    // START while busy is ignored
    a = 32'd1000; b = 32'd3; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; res = '0;
    for (int k = 0; k < 60; k++) begin
      if (k == 14) begin a = 32'd9; b = 32'd9; start = 1'b1; end
      if (k == 15) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; res = {hi, lo}; end
      @(posedge clk); #1;
    end
    chk("ignore_busy_cycles", 64'(busy_cnt), 64'(W + 1));
    chk("ignore_done_count", 64'(done_cnt), 64'd1);
    chk("ignore_result", res, 64'd3000);

    // reset mid-operation
    a = 32'd123; b = 32'd456; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("rst_abort_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    run_op("after_rst", 32'd7, 32'd6, 1'b0, 32'd0, 32'h2A, 1'b0);

    // back-to-back with START held
    a = 32'hFFFFFFF9; b = 32'd6; sgn = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    d0 = -1; d1 = -1;
    for (int k = 1; k < 120; k++) begin
      @(posedge clk); #1;
      if (done) begin
        chk($sformatf("b2b_result_k%0d", k), {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
        if (d0 < 0) d0 = k;
        else begin
          d1 = k;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_done", 64'(d0), 64'(W + 1));
    chk("b2b_spacing", 64'(d1 - d0), 64'(W + 2));
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle_after", {62'd0, busy, done}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
